foo_seq_engine: RTL and testbench
=================================

# foo_seq_engine

Parametrised, sequential successor to the combinational `foo` datapath. It computes `c = ((a + ADD_A) * (b + ADD_B) / DIVISOR + ADD_C)^2` in unsigned arithmetic modulo 2^WIDTH. Multiply and square run on single-cycle hardware; the division uses a shared iterative restoring divider. Operands and result pass through valid/ready handshakes, so the block sits behind a compiler-scheduled producer and ahead of a consumer that may stall.

## Interface
Parameters (name, default, meaning):
- WIDTH, 32: operand and result width; must be ≥ 2.
- ADD_A, 4: constant added to `a`.
- ADD_B, 7: constant added to `b`.
- DIVISOR, 3: constant divisor. Must satisfy 1 ≤ DIVISOR < 2^WIDTH. A simulation assertion fires at time 0 if this is violated.
- ADD_C, 120: constant added to the quotient.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock; everything is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: operand pair present.
- in_ready, out, 1: engine can accept an operand pair.
- a, in, WIDTH: operand a.
- b, in, WIDTH: operand b.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- c, out, WIDTH: result, registered.
- busy, out, 1: high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, MUL, DIV, POST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register t2=a+ADD_A and t4=b+ADD_B, each truncated to WIDTH; go to MUL.
- MUL:
  - t5 = (t2*t4)[WIDTH-1:0].
  - Load the divider: dividend=t5, remainder=0, bit counter=WIDTH-1.
  - Go to DIV.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, WIDTH cycles in total.
  - The remainder register is WIDTH+1 bits so the trial subtract never overflows.
  - After the cycle with counter==0, go to POST.
- POST: c register ← ((q+ADD_C)[WIDTH-1:0])², truncated to WIDTH; go to DONE.
- DONE:
  - out_valid=1; c is held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE. There is no overlap, so a new operand is accepted at the earliest in the cycle after the handshake.
- Only one operation is ever in flight. in_valid is ignored outside IDLE.
- Reset, including mid-operation:
  - State returns to IDLE; all datapath registers clear.
  - Any in-flight operation is discarded; no result is emitted.
- Reset values of outputs: in_ready=1 is not asserted in the reset cycle itself, but is 1 in the first cycle after reset. out_valid=0, c=0, busy=0.
- All arithmetic is unsigned and wraps modulo 2^WIDTH at every intermediate step (t2, t4, t5, q+ADD_C, square). This matches the truncation semantics of the baseline combinational block bit for bit.

## Timing
- Input handshake: in_valid && in_ready at edge N.
- State sequence after that edge: MUL during cycle N+1, DIV during cycles N+2 … N+WIDTH+1, POST during cycle N+WIDTH+2.
- out_valid rises in cycle N+WIDTH+3. Latency is WIDTH+3 cycles (35 for the default WIDTH=32).
- Throughput is one result per WIDTH+4 cycles with no backpressure. Each cycle out_ready is held low extends that by one cycle.
- in_ready, out_valid and busy are decoded purely from the registered state, with no combinational input→output paths.
- The producer may hold in_valid high while in_ready is low. The engine samples a and b only on the handshake edge.

## Structure
- Package `foo_seq_pkg` holds:
  - the `state_t` enum (IDLE, MUL, DIV, POST, DONE);
  - localparams for the default constants, shared with the golden model.
- One sub-module, `foo_seq_div`: the WIDTH-parameterised serial restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder. It uses the same clk/rst.
  - Its `done` pulse drives the DIV→POST transition.
- The top level contains the FSM, operand registers, the multiplier, the squarer and the output register.

## Test plan
- Default parameters, a=2, b=3, out_ready=1 → c=19600 (0x4C90). out_valid rises exactly 35 cycles after the accept edge.
- Default parameters, a=0, b=0 → c=16641. Also check in_ready=0 and busy=1 throughout the operation.
- Default parameters, a=0xFFFFFFFC, b=5 (t2 wraps to 0) → c=14400.
- Backpressure:
  - Result for a=2, b=3 with out_ready held low for 10 cycles → c stays 19600 and out_valid stays 1 for all 10 cycles.
  - When out_ready goes high, the handshake completes and in_ready=1 on the next cycle.
  - in_valid asserted during DONE is not accepted.
- Reset asserted for one cycle at DIV step 10 → the next cycle is IDLE with out_valid=0 and c=0. A subsequent a=0, b=0 completes with c=16641.
- WIDTH=8, DIVISOR=1, other defaults, a=2, b=1 → c=64 (168² mod 256) with latency 11 cycles. Back-to-back random operands must match the golden model across 1000 transactions.

Source files
------------

// File: rtl/foo_seq_pkg.sv
// foo_seq_pkg: shared types and default constants for the sequential foo engine.
// Contents:
//   state_t     - engine FSM states (IDLE, MUL, DIV, POST, DONE)
//   DEF_*       - default parameter values, also used by the testbench model
package foo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    POST,
    DONE
  } state_t;

  localparam int          DEF_WIDTH   = 32;
  localparam int unsigned DEF_ADD_A   = 4;
  localparam int unsigned DEF_ADD_B   = 7;
  localparam int unsigned DEF_DIVISOR = 3;
  localparam int unsigned DEF_ADD_C   = 120;

endpackage

// File: rtl/foo_seq_div.sv
// foo_seq_div: serial restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - load dividend; the next WIDTH cycles perform the division
//   dividend  - value sampled on start
//   divisor   - must be held stable for the whole division
//   done      - high during the cycle that computes the last quotient bit;
//               quotient/remainder are final from the following cycle on
//   quotient  - result, held until the next start
//   remainder - final remainder, held until the next start
module foo_seq_div
  import foo_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom, so after WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] dq;

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    rem_shift = {rem, dq[WIDTH-1]};
    trial     = rem_shift - {2'b00, divisor};
    fits      = ~trial[WIDTH+1];  // no borrow: divisor fits, quotient bit is 1
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      dq     <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      rem    <= '0;
      dq     <= dividend;
    end else if (active) begin
      dq  <= {dq[WIDTH-2:0], fits};
      rem <= fits ? trial[WIDTH:0] : rem_shift[WIDTH:0];
      cnt <= cnt - CW'(1);
      if (cnt == '0) active <= 1'b0;
    end
  end

  assign done      = active && (cnt == '0);
  assign quotient  = dq;
  assign remainder = rem[WIDTH-1:0];

endmodule

// File: rtl/foo_seq_engine.sv
// foo_seq_engine: c = ((a + ADD_A) * (b + ADD_B) / DIVISOR + ADD_C)^2 mod 2^WIDTH,
// one operation in flight, valid/ready on both sides.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (a, b sampled on the handshake edge)
//   a, b                - operands
//   out_valid, out_ready- result handshake; c held stable while out_valid
//   c                   - registered result
//   busy                - high whenever the engine is not IDLE
// Latency from accept edge to out_valid is WIDTH+3 cycles.
module foo_seq_engine
  import foo_seq_pkg::*;
#(
  parameter int          WIDTH   = DEF_WIDTH,
  parameter int unsigned ADD_A   = DEF_ADD_A,
  parameter int unsigned ADD_B   = DEF_ADD_B,
  parameter int unsigned DIVISOR = DEF_DIVISOR,
  parameter int unsigned ADD_C   = DEF_ADD_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("foo_seq_engine: WIDTH must be at least 2");
  end
  if ((DIVISOR == 0) || ((WIDTH < 32) && ((DIVISOR >> WIDTH) != 0))) begin : g_bad_divisor
    $error("foo_seq_engine: DIVISOR must satisfy 1 <= DIVISOR < 2**WIDTH");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] t2;
  logic [WIDTH-1:0] t4;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] square;

  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_rem_unused;

  // Truncating arithmetic: every intermediate wraps modulo 2^WIDTH.
  assign product = t2 * t4;
  assign sum_c   = div_q + WIDTH'(ADD_C);
  assign square  = sum_c * sum_c;

  // The product feeds the divider directly during MUL; it is sampled on
  // the MUL->DIV edge, so no separate t5 register is needed.
  foo_seq_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (product),
    .divisor  (WIDTH'(DIVISOR)),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_rem_unused)
  );

  // NOTE: datapath registers are reset too, so an aborted operation leaves
  // no stale operands or result visible on c after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t2    <= '0;
      t4    <= '0;
      c     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        t2 <= a + WIDTH'(ADD_A);
        t4 <= b + WIDTH'(ADD_B);
      end
      if (state == POST) c <= square;
    end
  end

  // Handshake outputs decode only the registered state: no input->output paths.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    div_start  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        div_start  = 1'b1;
        state_next = DIV;
      end
      DIV: begin
        if (div_done) state_next = POST;
      end
      POST: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_foo_seq_engine.sv
// tb_foo_seq_engine: self-checking bench for foo_seq_engine.
// Instance dut  : default parameters (WIDTH=32, DIVISOR=3).
// Instance dut8 : WIDTH=8, DIVISOR=1, back-to-back random traffic.
module tb_foo_seq_engine;
  import foo_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, c;
  // narrow instance
  logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8, c8;

  foo_seq_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  foo_seq_engine #(.WIDTH(8), .DIVISOR(1)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .busy(busy8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Golden model straight from the formula, masking at every step.
  function automatic logic [63:0] model_c(input int w, input longint unsigned dv,
                                          input longint unsigned av, input longint unsigned bv);
    longint unsigned mask, t2, t4, t5, q, s;
    mask = (64'd1 << w) - 64'd1;
    t2 = (av + 64'(DEF_ADD_A)) & mask;
    t4 = (bv + 64'(DEF_ADD_B)) & mask;
    t5 = (t2 * t4) & mask;
    q  = t5 / dv;
    s  = (q + 64'(DEF_ADD_C)) & mask;
    return (s * s) & mask;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair on dut, returns latency (accept edge to out_valid)
  // and the result seen when out_valid rises. Leaves the engine in DONE.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input string tag,
                        output int lat, output logic [31:0] res);
    logic bad;
    a = av;
    b = bv;
    in_valid = 1'b1;
    check({tag, " in_ready before accept"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    lat = 1;
    bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      tick;
      lat++;
    end
    check({tag, " in_ready=0/busy=1 during op"}, bad, 0);
    res = c;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_c;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs[3];
    int          lat;
    logic [31:0] res;
    logic        bad;
    logic [7:0]  expq[$];
    int          cyc, compared, last_acc, gap_bad;

    vecs[0] = '{"a2_b3",        32'd2,          32'd3, 32'd19600, 35};
    vecs[1] = '{"a0_b0",        32'd0,          32'd0, 32'd16641, 35};
    vecs[2] = '{"t2_wraps",     32'hFFFF_FFFC,  32'd5, 32'd14400, 35};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0;
    tick;
    tick;
    rst = 1'b0;
    rst8 = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset c", c, 0);
    check("reset busy", busy, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].name, lat, res);
      check({vecs[i].name, " c"}, res, vecs[i].exp_c);
      check({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
      tick;
      check({vecs[i].name, " in_ready after handshake"}, in_ready, 1);
      check({vecs[i].name, " out_valid after handshake"}, out_valid, 0);
    end

    // Backpressure: 10 cycles of out_ready=0 with in_valid offered in DONE
    out_ready = 1'b0;
    run_op(32'd2, 32'd3, "bp", lat, res);
    check("bp latency", lat, 35);
    for (int k = 0; k < 10; k++) begin
      check("bp out_valid held", out_valid, 1);
      check("bp c held", c, 32'd19600);
      check("bp in_ready low in DONE", in_ready, 0);
      a = 32'd0;
      b = 32'd0;
      in_valid = 1'b1;
      tick;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick;
    check("bp in_ready after handshake", in_ready, 1);
    check("bp out_valid after handshake", out_valid, 0);
    tick;
    tick;
    check("bp DONE-time in_valid not accepted", busy, 0);

    // Reset during DIV step 10
    a = 32'd5; b = 32'd9; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst c", c, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 1);
    bad = 1'b0;
    repeat (50) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick;
    end
    check("midrst no result emitted", bad, 0);
    run_op(32'd0, 32'd0, "after_rst", lat, res);
    check("after_rst c", res, 32'd16641);
    check("after_rst latency", lat, 35);
    tick;

    // Random operands with random stalls, default parameters
    for (int n = 0; n < 30; n++) begin
      logic [31:0] ra, rb;
      int          stall;
      ra = $urandom;
      rb = $urandom;
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      run_op(ra, rb, "rand32", lat, res);
      check("rand32 c", res, model_c(32, DEF_DIVISOR, ra, rb));
      check("rand32 latency", lat, 35);
      repeat (stall) begin
        tick;
        check("rand32 c stable", c, res);
      end
      out_ready = 1'b1;
      tick;
      check("rand32 out_valid drops", out_valid, 0);
    end

    // WIDTH=8, DIVISOR=1 directed
    a8 = 8'd2; b8 = 8'd1; in_valid8 = 1'b1;
    check("w8 in_ready before accept", in_ready8, 1);
    tick;
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    check("w8 c", c8, 8'd64);
    check("w8 latency", lat, 11);
    tick;

    // WIDTH=8 back-to-back random traffic against a scoreboard
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cyc = 0;
    compared = 0;
    last_acc = -1;
    gap_bad = 0;
    while (compared < 1000 && cyc < 20000) begin
      if (out_valid8 === 1'b1) begin
        if (expq.size() == 0) check("w8 unexpected result", 1, 0);
        else check("w8 rand c", c8, expq.pop_front());
        compared++;
      end
      if (in_ready8 === 1'b1) begin
        expq.push_back(8'(model_c(8, 1, a8, b8)));
        if (last_acc >= 0 && cyc - last_acc != 12) gap_bad++;
        last_acc = cyc;
      end
      tick;
      cyc++;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end
    in_valid8 = 1'b0;
    check("w8 results received", compared, 1000);
    check("w8 accept spacing WIDTH+4", gap_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
